// File: rtl/pipe_pkg.sv
// Shared helpers for the valid/ready queue blocks: pointer sizing, pointer compares
// and the per-cycle queue operation encoding.
package pipe_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } queue_op_e;

    // Never returns 0, so an index field always has at least one bit.
    function automatic int unsigned clog2_safe(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Pointers carry one extra wrap bit above the index bits; w is the full pointer width.
    function automatic logic ptr_empty(input logic [31:0] wr, input logic [31:0] rd,
                                       input int unsigned w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return ((wr ^ rd) & mask) == '0;
    endfunction

    function automatic logic ptr_full(input logic [31:0] wr, input logic [31:0] rd,
                                      input int unsigned w);
        logic [31:0] msb;
        logic [31:0] low;
        msb = 32'd1 << (w - 1);
        low = msb - 32'd1;
        return (((wr ^ rd) & low) == '0) && (((wr ^ rd) & msb) != '0);
    endfunction

endpackage

// File: rtl/pipe_ptr_ctrl.sv
// Read/write pointers, occupancy and registered status flags for a DEPTH-entry queue.
module pipe_ptr_ctrl
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AFULL = DEPTH - 1,
    localparam int PTR_W = clog2_safe(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             valid_in,
    input  logic             ready_in,
    output logic             push,
    output logic             pop,
    output logic [PTR_W-2:0] wr_idx,
    output logic [PTR_W-2:0] rd_idx_next,
    output logic             valid_out,
    output logic             ready_out,
    output logic [PTR_W-1:0] count,
    output logic             almost_full
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_next;
    logic [PTR_W-1:0] rd_next;
    logic [PTR_W-1:0] count_q;
    logic [PTR_W-1:0] count_next;
    logic             valid_q;
    logic             ready_q;
    logic             afull_q;
    queue_op_e        op;

    // Handshakes are qualified only by registered flags, keeping ready_out off ready_in.
    assign push = valid_in && ready_q;
    assign pop  = valid_q && ready_in;

    always_comb begin
        wr_next = wr_ptr;
        rd_next = rd_ptr;
        op      = queue_op_e'({push, pop});
        if (flush) begin
            wr_next = '0;
            rd_next = '0;
        end else begin
            case (op)
                OP_PUSH: wr_next = wr_ptr + PTR_W'(1);
                OP_POP:  rd_next = rd_ptr + PTR_W'(1);
                OP_BOTH: begin
                    wr_next = wr_ptr + PTR_W'(1);
                    rd_next = rd_ptr + PTR_W'(1);
                end
                default: ;
            endcase
        end
        count_next = wr_next - rd_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            afull_q <= 1'b0;
        end else begin
            wr_ptr  <= wr_next;
            rd_ptr  <= rd_next;
            count_q <= count_next;
            valid_q <= !ptr_empty(32'(wr_next), 32'(rd_next), PTR_W);
            ready_q <= !ptr_full(32'(wr_next), 32'(rd_next), PTR_W);
            afull_q <= (32'(count_next) >= 32'(AFULL));
        end
    end

    assign wr_idx      = wr_ptr[PTR_W-2:0];
    assign rd_idx_next = rd_next[PTR_W-2:0];
    assign valid_out   = valid_q;
    assign ready_out   = ready_q;
    assign count       = count_q;
    assign almost_full = afull_q;

endmodule

// File: rtl/pipeline_skid_fifo.sv
// DEPTH-entry elastic buffer on a valid/ready stream; all outputs come straight from flops.
module pipeline_skid_fifo
    import pipe_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AFULL = DEPTH - 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          valid_in,
    output logic          ready_out,
    input  logic [DW-1:0] data_in,
    output logic          valid_out,
    input  logic          ready_in,
    output logic [DW-1:0] data_out,
    output logic [CW-1:0] count,
    output logic          almost_full
);

    localparam int PTR_W = clog2_safe(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic [PTR_W-2:0] wr_idx;
    logic [PTR_W-2:0] rd_idx_next;
    logic [DW-1:0]    mem [DEPTH];
    logic [DW-1:0]    data_q;

    pipe_ptr_ctrl #(
        .DEPTH (DEPTH),
        .AFULL (AFULL)
    ) u_ptr_ctrl (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .push        (push),
        .pop         (pop),
        .wr_idx      (wr_idx),
        .rd_idx_next (rd_idx_next),
        .valid_out   (valid_out),
        .ready_out   (ready_out),
        .count       (count),
        .almost_full (almost_full)
    );

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_idx] <= data_in;
        end
    end

    // Head register is preloaded with the next head: either the entry being written
    // this cycle (buffer going from empty, or last entry popped) or the stored one.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            data_q <= '0;
        end else if (push || pop) begin
            if (push && (wr_idx == rd_idx_next)) begin
                data_q <= data_in;
            end else begin
                data_q <= mem[rd_idx_next];
            end
        end
    end

    assign data_out = data_q;

endmodule

// File: doc/pipeline_skid_fifo.md
Name: pipeline_skid_fifo

Overview:
- Parametrised successor to the single-stage pipeline skid buffer: a DEPTH-entry elastic buffer on a valid/ready stream.
- Every output is driven only from registers, so there is no combinational path from any input to any output. This breaks both the forward (valid/data) and backward (ready) timing paths between pipeline stages.
- Adds occupancy reporting, an almost-full flag and a synchronous flush.
- Sits between any two stages of the datapath pipelines (arbiter front-ends, request queues).

Parameters:
- DW, 8, payload width in bits (>=1).
- DEPTH, 4, number of storage entries; power of two, >=2.
- AFULL, DEPTH-1, almost_full asserts when count >= AFULL; legal range 1..DEPTH.
- CW, $clog2(DEPTH+1), width of count; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous discard of all stored entries.
- valid_in  in  1  upstream data valid.
- ready_out  out  1  buffer can accept (to upstream).
- data_in  in  DW  upstream payload.
- valid_out  out  1  head entry valid (to downstream).
- ready_in  in  1  downstream can accept.
- data_out  out  DW  head entry payload.
- count  out  CW  number of stored entries, 0..DEPTH.
- almost_full  out  1  count >= AFULL.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: valid_out=0, ready_out=1, count=0, almost_full=0, data_out=0. Read/write pointers are 0 and storage contents are don't-care.
- Push: occurs when valid_in && ready_out. data_in is written at the tail and the tail pointer advances.
- Pop: occurs when valid_out && ready_in. The head pointer advances.
- Pointers: log2(DEPTH)+1 bits wide, with the MSB as the wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ. Wrap from DEPTH-1 to 0 is natural modulo arithmetic.
- Status outputs:
  - valid_out = (count != 0).
  - ready_out = (count != DEPTH).
  - almost_full = (count >= AFULL).
  - All are functions of registered state only. ready_out must not depend on ready_in.
- count update, next cycle:
  - push without pop: +1.
  - pop without push: -1.
  - push and pop together: unchanged.
- Latency: a push into an empty buffer at edge N gives valid_out=1 with that data after edge N, i.e. one cycle of latency. Full throughput is one transfer per cycle in steady state.
- Full: ready_out=0. valid_in is ignored and data_in is not written. A pop while full frees the slot, and ready_out=1 on the following cycle. There is no same-cycle pass-through when full.
- Empty: valid_out=0 and ready_in is ignored. Push and pop together while empty means push only.
- Stability: while valid_out && !ready_in, data_out and valid_out hold unchanged.
- Ordering: strict FIFO. No entry is dropped or duplicated.
- Flush: takes priority over push and pop in the same cycle. On the next cycle count=0, valid_out=0, ready_out=1 and the pointers are reset. A push presented in a flush cycle is discarded.
- Priority: rst > flush > push/pop.
- Reset asserted mid-stream: all contents are lost and the outputs return to their reset values on the next edge.

Decomposition:
- Shared package pipe_pkg holds:
  - function clog2_safe(depth).
  - localparam PTR_W = $clog2(DEPTH)+1.
  - The full/empty pointer-compare function, reused by the other queue blocks.
- Sub-module pipe_ptr_ctrl (pointers, count, full/empty/almost_full) is natural. Storage is a plain register array in the top module.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles, then valid_in=0 → valid_out=0, ready_out=1, count=0, almost_full=0.
- Single pass: push 0xA5 while ready_in=1 → valid_out=1, data_out=0xA5 exactly one cycle later, count returns to 0 the cycle after.
- Fill and backpressure, DEPTH=4, ready_in=0: push 0x01..0x05 on consecutive cycles →
  - 0x01..0x04 are accepted.
  - ready_out=0 after the 4th push, and 0x05 is held upstream.
  - count=4, and almost_full=1 from count=3 onward.
  - data_out is stable at 0x01.
- Drain with wrap: continue from full, ready_in=1, valid_in=1 streaming 0x05..0x0C → output order 0x01..0x0C with no gaps after the first pop, and pointers wrap at least twice.
- Simultaneous push and pop at count=2 → count stays 2, and the order is preserved.
- Flush at count=3 with valid_in=1 in the same cycle → next cycle count=0, valid_out=0, ready_out=1. The subsequent push of 0x77 appears as the first output.
